cache_rd_arbiter: RTL
=====================

// Module: cache_rd_arbiter
// PURPOSE
//  Shares one AXI read-address/read-data channel pair between the icache and dcache refill ports.
//  Both ports use the cache-side rd_req/rd_rdy/ret_* handshake. One transaction is outstanding at a time.
//  The block sits between the two cache instances and the AXI bridge. Arbitration is round-robin by default.
// PARAMETERS
//  ADDR_WIDTH      32  width of rd_addr / araddr
//  FIXED_PRIORITY  0   1: dcache always wins a tie; 0: round-robin on ties
// PORTS
//  clk           in   1   clock, all logic on posedge
//  reset         in   1   synchronous, active-high reset
//  ic_rd_req     in   1   icache read request, held until ic_rd_rdy
//  ic_rd_type    in   3   000 byte, 001 half, 010 word, 100 cache line (4 words)
//  ic_rd_addr    in   AW  icache request start address
//  ic_rd_rdy     out  1   icache request accepted this cycle
//  ic_ret_valid  out  1   return beat valid for icache
//  ic_ret_last   out  2   {1'b0, last beat}
//  dc_rd_req     in   1   dcache read request, held until dc_rd_rdy
//  dc_rd_type    in   3   same encoding as ic_rd_type
//  dc_rd_addr    in   AW  dcache request start address
//  dc_rd_rdy     out  1   dcache request accepted this cycle
//  dc_ret_valid  out  1   return beat valid for dcache
//  dc_ret_last   out  2   {1'b0, last beat}
//  ret_data      out  32  return data, broadcast to both caches (= rdata)
//  araddr        out  AW  AXI read address
//  arlen         out  8   AXI burst length-1
//  arsize        out  3   AXI beat size
//  arvalid       out  1   AXI address valid
//  arready       in   1   AXI address ready
//  rdata         in   32  AXI read data
//  rlast         in   1   AXI last beat
//  rvalid        in   1   AXI read valid
//  rready        out  1   AXI read ready
// BEHAVIOUR
//  - FSM states IDLE, AR, R. Reset: state=IDLE; arvalid=0; rready=0; all rd_rdy/ret_valid/ret_last=0;
//    last_grant=IC (so dcache wins the first tie).
//  - IDLE: if only one rd_req is high, that port wins. If both are high, the winner is dcache when
//    FIXED_PRIORITY=1; otherwise it is the port not in last_grant.
//    The winner's rd_rdy=1 combinationally in the same cycle.
//    Latch addr, type and owner; update last_grant; go to AR next cycle.
//  - rd_rdy is 0 outside IDLE, so a new grant can occur only in IDLE.
//  - AR: arvalid=1 with araddr/arlen/arsize from the latched request, stable until arready.
//    On arvalid&arready: go to R next cycle, with arvalid=0 in that cycle.
//  - Type decode: 100 -> arlen=3, arsize=2; 000 -> arlen 0, size 0; 001 -> arlen 0, size 1;
//    010 and any other code -> arlen 0, size 2.
//  - R: rready=1. Owner's ret_valid=rvalid and ret_last={1'b0,rlast}, combinationally.
//    The non-owner's ret_valid=0. On rvalid&rlast: go to IDLE.
//  - rvalid outside R is not accepted (rready=0) and is not forwarded.
//  - Minimum gap: the rlast cycle is followed by one IDLE cycle (grant), then AR.
//    A back-to-back request is therefore granted 1 cycle after rlast.
//  - A request that drops before acceptance is not granted. Requests are never queued internally.
//  - Reset mid-transaction: the block returns to IDLE next cycle. The AXI slave resets in the same domain.
// TESTING
//  - Single dcache line read, addr 0x1C000040, type 100: dc_rd_rdy=1 in the same cycle; araddr=0x1C000040,
//    arlen=3, arsize=2; 4 beats -> dc_ret_valid x4, ret_last[0]=1 only on beat 4; ic_ret_valid stays 0.
//  - Both requests in the same cycle after reset, RR mode: dcache granted first. icache is granted in the
//    IDLE cycle after dcache's rlast. A third simultaneous pair grants dcache again.
//  - FIXED_PRIORITY=1, continuous dc_rd_req with ic_rd_req: icache is starved and dcache is always granted.
//  - arready held low 5 cycles: arvalid stays 1 and araddr stays stable; no rready before the handshake.
//  - Uncached byte read, type 000, addr 0xBFAF8003: arlen=0, arsize=0; single beat with ret_last[0]=1.
//  - reset asserted during the R beat 2: next cycle state=IDLE, rready=0, all ret_valid=0;
//    a fresh request afterwards completes normally.

Source files
------------

// File: rtl/cache_rd_arbiter.sv
// ----------------------------------------------------------------------------
// cache_rd_arbiter
//
// Purpose:
//   Shares a single AXI read-address / read-data channel pair between the
//   icache and dcache refill ports. Each cache uses the rd_req/rd_rdy request
//   handshake and the ret_valid/ret_last return interface. Only one read is
//   outstanding at a time. Ties go round-robin, or always to the dcache when
//   FIXED_PRIORITY is set.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   ic_rd_req/type/addr, ic_rd_rdy  icache request handshake
//   ic_ret_valid, ic_ret_last     icache return beat qualifiers
//   dc_rd_req/type/addr, dc_rd_rdy  dcache request handshake
//   dc_ret_valid, dc_ret_last     dcache return beat qualifiers
//   ret_data                      return data, broadcast to both caches
//   araddr/arlen/arsize/arvalid/arready   AXI read address channel
//   rdata/rlast/rvalid/rready             AXI read data channel
// ----------------------------------------------------------------------------
module cache_rd_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_rd_req,
    input  logic [2:0]            ic_rd_type,
    input  logic [ADDR_WIDTH-1:0] ic_rd_addr,
    output logic                  ic_rd_rdy,
    output logic                  ic_ret_valid,
    output logic [1:0]            ic_ret_last,

    input  logic                  dc_rd_req,
    input  logic [2:0]            dc_rd_type,
    input  logic [ADDR_WIDTH-1:0] dc_rd_addr,
    output logic                  dc_rd_rdy,
    output logic                  dc_ret_valid,
    output logic [1:0]            dc_ret_last,

    output logic [31:0]           ret_data,

    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [31:0]           rdata,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    last_grant_dc;
    logic                    owner_dc;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [2:0]              req_type;
    logic                    ic_win;
    logic                    dc_win;
    logic                    grant;

    // Arbitration. The dcache wins when it is the only requester, or on a tie
    // when priority is fixed or the icache held the previous grant.
    always_comb begin
        dc_win = dc_rd_req & (~ic_rd_req | FIXED_PRIORITY | ~last_grant_dc);
        ic_win = ic_rd_req & ~dc_win;
        grant  = (state == IDLE) & ~reset & (ic_win | dc_win);
    end

    // Next-state logic: a grant moves to AR, the address handshake to R,
    // and the last accepted data beat back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant)           state_next = AR;
            AR:   if (arready)         state_next = R;
            R:    if (rvalid && rlast) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // State register and latched request. A grant captures the winner's
    // address, type and identity; the round-robin pointer follows the winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant_dc <= 1'b0;
            owner_dc      <= 1'b0;
            req_addr      <= '0;
            req_type      <= 3'b000;
        end else begin
            state <= state_next;
            if (grant) begin
                owner_dc      <= dc_win;
                last_grant_dc <= dc_win;
                req_addr      <= dc_win ? dc_rd_addr : ic_rd_addr;
                req_type      <= dc_win ? dc_rd_type : ic_rd_type;
            end
        end
    end

    // Request type to AXI burst decode. Only the cache-line type bursts;
    // unknown codes fall back to a single word beat.
    always_comb begin
        arlen  = 8'd0;
        arsize = 3'd2;
        case (req_type)
            3'b100:  begin arlen = 8'd3; arsize = 3'd2; end
            3'b000:  begin arlen = 8'd0; arsize = 3'd0; end
            3'b001:  begin arlen = 8'd0; arsize = 3'd1; end
            default: begin arlen = 8'd0; arsize = 3'd2; end
        endcase
    end

    // Handshake and return outputs. Everything is forced quiet while reset is
    // asserted so neither cache nor the AXI slave sees a half-reset transfer.
    // Return beats are steered combinationally to the owner only.
    always_comb begin
        ic_rd_rdy    = 1'b0;
        dc_rd_rdy    = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        ic_ret_valid = 1'b0;
        dc_ret_valid = 1'b0;
        ic_ret_last  = 2'b00;
        dc_ret_last  = 2'b00;
        araddr       = req_addr;
        ret_data     = rdata;
        if (!reset) begin
            case (state)
                IDLE: begin
                    ic_rd_rdy = ic_win;
                    dc_rd_rdy = dc_win;
                end
                AR: begin
                    arvalid = 1'b1;
                end
                R: begin
                    rready = 1'b1;
                    if (owner_dc) begin
                        dc_ret_valid = rvalid;
                        dc_ret_last  = {1'b0, rlast};
                    end else begin
                        ic_ret_valid = rvalid;
                        ic_ret_last  = {1'b0, rlast};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
